// File: rtl/register_file_param.sv
// ============================================================================
// register_file_param: DEPTH x WIDTH register file, entry 0 reads as zero.
// Optional macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read forward).
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrenable,
  input  logic [ADDR_W-1:0]    writeregister,
  input  logic [WIDTH-1:0]     writedata,
  input  logic [WIDTH/8-1:0]   wrstrobe,
  input  logic [ADDR_W-1:0]    readregister1,
  input  logic [ADDR_W-1:0]    readregister2,
  output logic [WIDTH-1:0]     readdata1,
  output logic [WIDTH-1:0]     readdata2
);

  localparam int LANES = WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [1:DEPTH-1];
  logic [WIDTH-1:0] mem_d [1:DEPTH-1];

  logic             wr_valid;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;
  logic [WIDTH-1:0] stored_wr;
  logic [WIDTH-1:0] merged;

  assign wr_valid = wrenable && !reset && (|wrstrobe) &&
                    (writeregister != '0) &&
                    ({1'b0, writeregister} < DEPTH_W);

  always_comb begin
    stored1   = '0;
    stored2   = '0;
    stored_wr = '0;
    for (int e = 1; e < DEPTH; e++) begin
      if ({1'b0, readregister1} == (ADDR_W + 1)'(e)) stored1   = mem_q[e];
      if ({1'b0, readregister2} == (ADDR_W + 1)'(e)) stored2   = mem_q[e];
      if ({1'b0, writeregister} == (ADDR_W + 1)'(e)) stored_wr = mem_q[e];
    end
  end

  always_comb begin
    merged = stored_wr;
    for (int i = 0; i < LANES; i++) begin
      if (wrstrobe[i]) merged[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  always_comb begin
    for (int e = 1; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      if (wr_valid && ({1'b0, writeregister} == (ADDR_W + 1)'(e))) mem_d[e] = merged;
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 1; e < DEPTH; e++) begin
      if (reset) mem_q[e] <= '0;
      else       mem_q[e] <= mem_d[e];
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // wr_valid already excludes entry 0, out-of-range targets and reset.
  always_comb begin
    readdata1 = stored1;
    readdata2 = stored2;
    if (wr_valid && (readregister1 == writeregister)) readdata1 = merged;
    if (wr_valid && (readregister2 == writeregister)) readdata2 = merged;
  end
`else
  always_comb begin
    readdata1 = stored1;
    readdata2 = stored2;
  end
`endif

endmodule

`default_nettype wire

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised register file. Successor to the fixed 32-bit enable register and zero register.
- Storage: DEPTH words of WIDTH bits, two asynchronous read ports, one synchronous write port.
- Per-byte write strobes.
- Entry 0 is hardwired to zero.
- Synchronous clear of all entries on reset.
- Sits in the CPU datapath between decode and ALU. Replaces the hand-instantiated array of 32-bit registers.

Parameters:
- WIDTH, 32, data word width in bits. Must be a multiple of 8.
- DEPTH, 32, number of entries. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 5, width of the register address fields.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high. Clears all entries at the next rising edge of clk.
- wrenable  input  1  write enable. Sampled at the rising edge of clk.
- writeregister  input  ADDR_W  write address.
- writedata  input  WIDTH  write data.
- wrstrobe  input  WIDTH/8  byte-lane write mask. Bit i governs writedata[8i+7:8i].
- readregister1  input  ADDR_W  read address, port 1.
- readregister2  input  ADDR_W  read address, port 2.
- readdata1  output  WIDTH  read data, port 1.
- readdata2  output  WIDTH  read data, port 2.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). No other clock or asynchronous control exists.
- State: mem[1..DEPTH-1], each WIDTH bits. Entry 0 has no storage.
- Reset: at a rising edge with reset=1, every entry becomes 0.
  - Reset has priority over any concurrent write. A write in the reset cycle is discarded.
  - Power-up contents are undefined until the first reset edge.
- Reset mid-operation: a one-cycle reset pulse between writes clears everything. Earlier writes are lost. Writes after reset deasserts proceed normally.
- Write: at a rising edge with reset=0, wrenable=1, 1 <= writeregister < DEPTH:
  - for each lane i with wrstrobe[i]=1, mem[writeregister] lane i takes writedata lane i;
  - lanes with wrstrobe[i]=0 hold their value.
- No write occurs when any of the following holds:
  - wrenable=0;
  - wrstrobe is all zeros;
  - writeregister=0;
  - writeregister >= DEPTH.
- Write latency: the new value is visible on the read ports after the edge, in the same cycle, through combinational read.
- Read: combinational. There is no read clock or read enable.
  - readdataN = 0 when readregisterN = 0.
  - readdataN = 0 when readregisterN >= DEPTH.
  - Otherwise readdataN = mem[readregisterN].
  - Both ports may address the same entry. They then return identical data.
- Same-cycle read/write, default build: a read of the entry being written returns the pre-edge value until the edge. Pure flip-flop semantics apply.
- Width rules:
  - No arithmetic is performed.
  - Address comparisons against DEPTH use ADDR_W+1 bits to avoid wrap when DEPTH = 2**ADDR_W.
- Outputs after reset: readdata1 = readdata2 = 0 for every address.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when wrenable=1, reset=0, writeregister is valid and nonzero, and readregisterN = writeregister, then readdataN is the bypassed value combinationally in the same cycle, before the edge.
  - Bypassed value: writedata on strobed lanes, current mem contents on unstrobed lanes.
  - Reads of entry 0 still return 0.
  - Reads during reset=1 are not bypassed.
- Undefined: the read ports show stored contents only, as described under Behaviour.

Test Plan:
- Reset clear: write 32'd123456789 to entry 5, pulse reset for 1 cycle, then read entry 5 on both ports -> readdata1 = readdata2 = 0.
- Enable gating: wrenable=0, writedata=32'd666666, writeregister=7, one edge -> entry 7 unchanged (0). Repeat with wrenable=1 -> readdata1 = 666666 after the edge.
- Zero entry: wrenable=1, writeregister=0, writedata=32'hFFFFFFFF, wrstrobe=4'hF, edge -> readregister1=0 gives 0.
- Byte strobes: entry 3 = 32'h11223344; write 32'hAABBCCDD with wrstrobe=4'b0101 -> readdata = 32'h11BB33DD.
- Priority and range:
  - reset=1 with wrenable=1 to entry 9 -> entry 9 = 0.
  - With DEPTH=24, a write to address 30 -> ignored, read of 30 = 0, entry 30-DEPTH+… untouched (spot-check entries 6 and 23 unchanged).
- Same-cycle read of write target: readregister2 = writeregister = 4, writedata = 32'd42, old value 32'd7.
  - Before the edge, without the macro -> 7; with REGFILE_WRITE_BYPASS_EN -> 42.
  - After the edge, both builds -> 42.
